// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

   localparam logic OVERLAP     = 1'b1;
   localparam logic NON_OVERLAP = 1'b0;

   function automatic int unsigned len_width(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len < 2) return 2;
      if (len > max_len) return max_len;
      return len;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clr) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seq_det_param.sv
// Programmable serial bit-pattern detector with overlap control and a saturating match counter.
module seq_det_param
   import seq_det_pkg::*;
#(
   parameter int unsigned          MAX_LEN     = 8,
   parameter logic [MAX_LEN-1:0]   RST_PATTERN = 8'b0000_1001,
   parameter int unsigned          RST_LEN     = 4,
   parameter int unsigned          CNT_W       = 8,
   localparam int unsigned         LW          = len_width(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               data_valid,
   input  logic               data_in,
   input  logic               overlap,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cnt_clr,
   output logic               det_out,
   output logic [CNT_W-1:0]   match_cnt
);

   // Only MAX_LEN-1 old bits are kept; the incoming bit completes the window.
   logic [MAX_LEN-2:0] hist_q;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] pattern_q;
   logic [MAX_LEN-1:0] len_mask;
   logic [LW-1:0]      len_q;
   logic [LW-1:0]      fill_q;
   logic [LW-1:0]      fill_next;
   logic [LW-1:0]      cfg_len_cl;
   logic               det_q;
   logic               match;

   always_comb begin
      hist_next  = {hist_q, data_in};
      fill_next  = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      cfg_len_cl = LW'(clamp_len(32'(cfg_len), MAX_LEN));
      len_mask   = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < 32'(len_q));
      end
      match = data_valid && !cfg_load && (fill_next >= len_q) &&
              (((hist_next ^ pattern_q) & len_mask) == '0);
   end

   // fill_q acts as the EMPTY / FILLING / ARMED state of the detector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q    <= '0;
         fill_q    <= '0;
         pattern_q <= RST_PATTERN;
         len_q     <= LW'(RST_LEN);
         det_q     <= 1'b0;
      end else if (cfg_load) begin
         pattern_q <= cfg_pattern;
         len_q     <= cfg_len_cl;
         fill_q    <= '0;
         det_q     <= 1'b0;
      end else if (data_valid) begin
         hist_q <= hist_next[MAX_LEN-2:0];
         fill_q <= (match && (overlap == NON_OVERLAP)) ? '0 : fill_next;
         det_q  <= match;
      end else begin
         det_q <= 1'b0;
      end
   end

   assign det_out = det_q;

   sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (match),
      .clr     (cnt_clr),
      .count   (match_cnt)
   );

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench: stimulus queues expected pulses, a monitor pops them when det_out fires.
module tb_seq_det_param;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       data_valid;
   logic       data_in;
   logic       overlap;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cnt_clr;
   logic       det_a, det_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   typedef struct {
      int edge_no;
      int cnt_a;
      int cnt_b;
   } exp_t;

   exp_t exp_q[$];
   int   edge_no  = 0;
   int   checks   = 0;
   int   failures = 0;
   int   exp_a    = 0;
   int   exp_b    = 0;

   always #5 clk = ~clk;

   seq_det_param u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .overlap     (overlap),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cnt_clr     (cnt_clr),
      .det_out     (det_a),
      .match_cnt   (cnt_a)
   );

   seq_det_param #(
      .CNT_W (2)
   ) u_sat (
      .clk         (clk),
      .reset_n     (reset_n),
      .data_valid  (data_valid),
      .data_in     (data_in),
      .overlap     (overlap),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cnt_clr     (cnt_clr),
      .det_out     (det_b),
      .match_cnt   (cnt_b)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // Monitor: any pulse on either DUT must match the head of the scoreboard.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (det_a || det_b) begin
         if (exp_q.size() == 0) begin
            check("spurious_pulse", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_edge", edge_no, e.edge_no);
            check("pulse_a", int'(det_a), 1);
            check("pulse_b", int'(det_b), 1);
            check("cnt_a_at_pulse", int'(cnt_a), e.cnt_a);
            check("cnt_b_at_pulse", int'(cnt_b), e.cnt_b);
         end
      end
   end

   task automatic send(input logic v, input logic d, input logic p, input logic clr);
      exp_t e;
      data_valid = v;
      data_in    = d;
      cnt_clr    = clr;
      if (clr) begin
         exp_a = 0;
         exp_b = 0;
      end else if (p) begin
         if (exp_a < 255) exp_a++;
         if (exp_b < 3) exp_b++;
      end
      if (p) begin
         e.edge_no = edge_no + 1;
         e.cnt_a   = exp_a;
         e.cnt_b   = exp_b;
         exp_q.push_back(e);
      end
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      data_valid = 1'b0;
      cnt_clr    = 1'b0;
   endtask

   task automatic run(input string bits, input string exp);
      for (int i = 0; i < bits.len(); i++) begin
         send(1'b1, bits[i] == "1", exp[i] == "1", 1'b0);
      end
   endtask

   // The bit presented on the load edge must be discarded.
   task automatic cfg(input logic [7:0] pat, input logic [3:0] len);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_load    = 1'b1;
      data_valid  = 1'b1;
      data_in     = 1'b1;
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      cfg_load   = 1'b0;
      data_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      exp_a   = 0;
      exp_b   = 0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic end_scenario(input string name);
      check({name, "_missed_pulse"}, exp_q.size(), 0);
      check({name, "_cnt_a"}, int'(cnt_a), exp_a);
      check({name, "_cnt_b"}, int'(cnt_b), exp_b);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n     = 1'b0;
      data_valid  = 1'b0;
      data_in     = 1'b0;
      overlap     = 1'b0;
      cfg_load    = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cnt_clr     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_det", int'(det_a), 0);
      check("reset_cnt_a", int'(cnt_a), 0);
      check("reset_cnt_b", int'(cnt_b), 0);
      reset_n = 1'b1;

      // Non-overlap: trailing 001 must not match because fill restarted.
      overlap = 1'b0;
      run("1001001", "0001000");
      end_scenario("nonoverlap");

      do_reset();
      overlap = 1'b1;
      run("1001001", "0001001");
      end_scenario("overlap");

      // Upper pattern bits set to 1 must be ignored at len 3.
      do_reset();
      overlap = 1'b1;
      cfg(8'b1111_0101, 4'd3);
      run("10101", "00101");
      end_scenario("len3");

      // len 1 clamps to 2: a single 1 must not match.
      cfg(8'b0000_0011, 4'd1);
      run("0111", "0011");
      end_scenario("clamp_lo");

      // len 15 clamps to 8.
      cfg(8'hA5, 4'd15);
      run("10100101", "00000001");
      end_scenario("clamp_hi");

      // Gaps with toggling data must be invisible.
      do_reset();
      overlap = 1'b0;
      send(1'b1, 1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b1, 1'b0);
      end_scenario("gaps");

      // Four overlapping matches saturate the 2-bit counter; clear beats a match.
      do_reset();
      overlap = 1'b1;
      run("1001001001001", "0001001001001");
      end_scenario("saturate");
      send(1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0, 1'b0);
      send(1'b1, 1'b1, 1'b1, 1'b1);
      end_scenario("clr_prio");

      // Asynchronous reset while det_out is high and the counter is non-zero.
      do_reset();
      overlap = 1'b0;
      run("1001", "0001");
      check("det_before_rst", int'(det_a), 1);
      #1 reset_n = 1'b0;
      exp_a = 0;
      exp_b = 0;
      #1;
      check("det_async_rst", int'(det_a), 0);
      check("cnt_a_async_rst", int'(cnt_a), 0);
      @(negedge clk);
      reset_n = 1'b1;
      // Partial 100 must be lost across a mid-stream reset.
      run("100", "000");
      #1 reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      run("1", "0");
      run("001", "001");
      end_scenario("async_rst");

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
